// File: rtl/long_op_ctrl.sv
// Sequencer for the shared-result-path multi-cycle units (MUL, DIV, FPU).
// Issues start pulses, stalls the pipe until completion, and raises a writeback pulse with the destination tag.
module long_op_ctrl #(
    parameter int MUL_LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       issue_valid_i,
    input  logic [1:0] issue_unit_i,
    input  logic [4:0] issue_rd_i,
    input  logic       issue_rd_bank_i,
    input  logic       flush_i,
    input  logic       div_done_i,
    input  logic       fpu_done_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs_bank_i,
    output logic       mul_start_o,
    output logic       div_start_o,
    output logic       fpu_start_o,
    output logic       unit_kill_o,
    output logic       stall_o,
    output logic       busy_o,
    output logic [1:0] result_sel_o,
    output logic       wb_valid_o,
    output logic [4:0] wb_rd_o,
    output logic       wb_rd_bank_o,
    output logic       raw_hazard_o
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        FPU_WAIT,
        WB
    } state_t;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_FPU = 2'd1;
    localparam logic [1:0] UNIT_MUL = 2'd2;
    localparam logic [1:0] UNIT_DIV = 2'd3;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] unit_q;
    logic [4:0] rd_q;
    logic       bank_q;

    logic       in_wait;
    logic       in_wb;
    logic       accept;
    logic [3:0] cnt_dec;

    always_comb begin
        in_wait = (state == MUL_WAIT) || (state == DIV_WAIT) || (state == FPU_WAIT);
        in_wb   = (state == WB);
        // Reset is folded in so the combinational start/stall paths are quiet while rst_n_i is low.
        accept  = rst_n_i & issue_valid_i & (issue_unit_i != UNIT_ALU) & ~flush_i
                & ((state == IDLE) | in_wb);
        cnt_dec = cnt - 4'd1;

        mul_start_o  = accept & (issue_unit_i == UNIT_MUL);
        div_start_o  = accept & (issue_unit_i == UNIT_DIV);
        fpu_start_o  = accept & (issue_unit_i == UNIT_FPU);
        unit_kill_o  = in_wait & flush_i;
        stall_o      = accept | in_wait;
        busy_o       = in_wait | in_wb;
        result_sel_o = in_wb ? unit_q : UNIT_ALU;
        wb_valid_o   = in_wb & ~flush_i;
        wb_rd_o      = in_wb ? rd_q : 5'd0;
        wb_rd_bank_o = in_wb & bank_q;
        // x0 in the integer bank is hardwired zero and never a real dependency.
        raw_hazard_o = busy_o & (id_rs_bank_i == bank_q)
                     & ((id_rs1_i == rd_q) | (id_rs2_i == rd_q))
                     & ~(~bank_q & (rd_q == 5'd0));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            unit_q <= 2'd0;
            rd_q   <= 5'd0;
            bank_q <= 1'b0;
        end else begin
            case (state)
                IDLE, WB: begin
                    if (accept) begin
                        unit_q <= issue_unit_i;
                        rd_q   <= issue_rd_i;
                        bank_q <= issue_rd_bank_i;
                        case (issue_unit_i)
                            UNIT_MUL: begin
                                cnt   <= MUL_LOAD;
                                // Single-cycle multiplier completes straight into WB.
                                state <= (MUL_LOAD == 4'd0) ? WB : MUL_WAIT;
                            end
                            UNIT_DIV: state <= DIV_WAIT;
                            default:  state <= FPU_WAIT;
                        endcase
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL_WAIT: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_dec;
                        if (cnt_dec == 4'd0) state <= WB;
                    end
                end
                DIV_WAIT: begin
                    if (flush_i)         state <= IDLE;
                    else if (div_done_i) state <= WB;
                end
                FPU_WAIT: begin
                    if (flush_i)         state <= IDLE;
                    else if (fpu_done_i) state <= WB;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_long_op_ctrl.sv
// Self-checking bench for long_op_ctrl: per-scenario tasks plus a writeback scoreboard.
module tb_long_op_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [1:0] issue_unit;
    logic [4:0] issue_rd;
    logic       issue_rd_bank;
    logic       flush;
    logic       div_done;
    logic       fpu_done;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs_bank;
    logic       mul_start, div_start, fpu_start, unit_kill, stall, busy;
    logic [1:0] result_sel;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_rd_bank;
    logic       raw_hazard;

    typedef struct {
        logic [4:0] rd;
        logic       bank;
        logic [1:0] sel;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int checks = 0;
    int passed = 0;

    long_op_ctrl #(.MUL_LATENCY(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .issue_valid_i(issue_valid), .issue_unit_i(issue_unit),
        .issue_rd_i(issue_rd), .issue_rd_bank_i(issue_rd_bank),
        .flush_i(flush), .div_done_i(div_done), .fpu_done_i(fpu_done),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs_bank_i(id_rs_bank),
        .mul_start_o(mul_start), .div_start_o(div_start), .fpu_start_o(fpu_start),
        .unit_kill_o(unit_kill), .stall_o(stall), .busy_o(busy),
        .result_sel_o(result_sel), .wb_valid_o(wb_valid),
        .wb_rd_o(wb_rd), .wb_rd_bank_o(wb_rd_bank), .raw_hazard_o(raw_hazard)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Scoreboard: every writeback pulse must match the oldest outstanding accepted op.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_wb: got rd=%0d bank=%0d sel=%0d, required no writeback",
                         wb_rd, wb_rd_bank, result_sel);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                if (wb_rd !== e.rd || wb_rd_bank !== e.bank || result_sel !== e.sel)
                    $display("FAIL sb_wb: got rd=%0d bank=%0d sel=%0d, required rd=%0d bank=%0d sel=%0d",
                             wb_rd, wb_rd_bank, result_sel, e.rd, e.bank, e.sel);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        issue_valid = 0; issue_unit = 0; issue_rd = 0; issue_rd_bank = 0;
        flush = 0; div_done = 0; fpu_done = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs_bank = 0;
    endtask

    task automatic issue(input logic [1:0] unit, input logic [4:0] rd, input logic bank);
        issue_valid = 1; issue_unit = unit; issue_rd = rd; issue_rd_bank = bank;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clr_inputs();
        issue(2'd2, 5'd3, 1'b0);
        #3;
        checks++; if (mul_start !== 1'b0) $display("FAIL rst_mul_start: got %b required 0", mul_start); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b required 0", stall); else passed++;
        checks++; if ({busy, wb_valid, result_sel, wb_rd, raw_hazard, unit_kill} !== 11'd0)
            $display("FAIL rst_outputs: got %b required 0", {busy, wb_valid, result_sel, wb_rd, raw_hazard, unit_kill});
        else passed++;
        clr_inputs();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_mul();
        issue(2'd2, 5'd5, 1'b0);
        exp_q.push_back('{5'd5, 1'b0, 2'd2});
        #1;
        checks++; if (mul_start !== 1'b1) $display("FAIL mul_start_c0: got %b required 1", mul_start); else passed++;
        checks++; if (stall !== 1'b1) $display("FAIL mul_stall_c0: got %b required 1", stall); else passed++;
        tick(); clr_inputs(); #1;
        checks++; if (stall !== 1'b1 || mul_start !== 1'b0)
            $display("FAIL mul_c1: got stall=%b start=%b required stall=1 start=0", stall, mul_start);
        else passed++;
        tick(); #1;
        checks++; if (wb_valid !== 1'b1 || result_sel !== 2'd2 || wb_rd !== 5'd5 || stall !== 1'b0)
            $display("FAIL mul_wb_c2: got vld=%b sel=%0d rd=%0d stall=%b required 1/2/5/0", wb_valid, result_sel, wb_rd, stall);
        else passed++;
        tick(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL mul_idle_c3: got busy=%b required 0", busy); else passed++;
    endtask

    task automatic test_div();
        issue(2'd3, 5'd7, 1'b0);
        div_done = 1;                       // ignored: not yet in the wait state
        exp_q.push_back('{5'd7, 1'b0, 2'd3});
        #1;
        checks++; if (div_start !== 1'b1 || stall !== 1'b1)
            $display("FAIL div_c0: got start=%b stall=%b required 1/1", div_start, stall);
        else passed++;
        for (int c = 1; c <= 10; c++) begin
            tick(); clr_inputs();
            id_rs1 = 5'd1; id_rs2 = 5'd7; id_rs_bank = 1'b0;
            div_done = (c == 10);
            #1;
            checks++; if (stall !== 1'b1 || raw_hazard !== 1'b1)
                $display("FAIL div_wait_c%0d: got stall=%b hazard=%b required 1/1", c, stall, raw_hazard);
            else passed++;
        end
        tick(); div_done = 0; #1;
        checks++; if (wb_valid !== 1'b1 || result_sel !== 2'd3 || stall !== 1'b0)
            $display("FAIL div_wb_c11: got vld=%b sel=%0d stall=%b required 1/3/0", wb_valid, result_sel, stall);
        else passed++;
        tick(); clr_inputs(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL div_idle: got busy=%b required 0", busy); else passed++;
    endtask

    task automatic test_fpu_bank();
        issue(2'd1, 5'd3, 1'b1);
        exp_q.push_back('{5'd3, 1'b1, 2'd1});
        #1;
        checks++; if (fpu_start !== 1'b1) $display("FAIL fpu_start: got %b required 1", fpu_start); else passed++;
        tick(); clr_inputs();
        id_rs1 = 5'd3; id_rs_bank = 1'b0; #1;
        checks++; if (raw_hazard !== 1'b0) $display("FAIL fpu_hazard_xbank: got %b required 0", raw_hazard); else passed++;
        id_rs_bank = 1'b1; #1;
        checks++; if (raw_hazard !== 1'b1) $display("FAIL fpu_hazard_fbank: got %b required 1", raw_hazard); else passed++;
        tick(); div_done = 1; #1;           // wrong unit's done must be ignored
        tick(); div_done = 0; #1;
        checks++; if (stall !== 1'b1 || wb_valid !== 1'b0)
            $display("FAIL fpu_ignore_div_done: got stall=%b vld=%b required 1/0", stall, wb_valid);
        else passed++;
        fpu_done = 1;
        tick(); fpu_done = 0; #1;
        checks++; if (wb_valid !== 1'b1 || wb_rd_bank !== 1'b1 || result_sel !== 2'd1 || wb_rd !== 5'd3)
            $display("FAIL fpu_wb: got vld=%b bank=%b sel=%0d rd=%0d required 1/1/1/3", wb_valid, wb_rd_bank, result_sel, wb_rd);
        else passed++;
        tick(); clr_inputs(); #1;
    endtask

    task automatic test_back_to_back();
        issue(2'd2, 5'd9, 1'b0);
        exp_q.push_back('{5'd9, 1'b0, 2'd2});
        tick(); clr_inputs();
        tick();
        issue(2'd2, 5'd10, 1'b0);
        exp_q.push_back('{5'd10, 1'b0, 2'd2});
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || mul_start !== 1'b1 || stall !== 1'b1)
            $display("FAIL b2b_wb1: got vld=%b rd=%0d start=%b stall=%b required 1/9/1/1", wb_valid, wb_rd, mul_start, stall);
        else passed++;
        tick(); clr_inputs(); #1;
        checks++; if (stall !== 1'b1 || wb_valid !== 1'b0)
            $display("FAIL b2b_wait: got stall=%b vld=%b required 1/0", stall, wb_valid);
        else passed++;
        tick(); #1;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd10)
            $display("FAIL b2b_wb2: got vld=%b rd=%0d required 1/10", wb_valid, wb_rd);
        else passed++;
        tick(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b required 0", busy); else passed++;
    endtask

    task automatic test_flush();
        issue(2'd3, 5'd4, 1'b0);
        tick(); clr_inputs();
        tick(); tick();
        tick();
        flush = 1; issue(2'd2, 5'd8, 1'b0); #1;
        checks++; if (unit_kill !== 1'b1 || mul_start !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL flush_kill_c4: got kill=%b start=%b vld=%b required 1/0/0", unit_kill, mul_start, wb_valid);
        else passed++;
        tick(); clr_inputs(); #1;
        checks++; if (busy !== 1'b0 || stall !== 1'b0)
            $display("FAIL flush_idle_c5: got busy=%b stall=%b required 0/0", busy, stall);
        else passed++;
        tick(); div_done = 1; #1;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_late_done: got vld=%b busy=%b required 0/0", wb_valid, busy);
        else passed++;
        tick(); clr_inputs();
        // Flush landing in the WB cycle.
        issue(2'd2, 5'd6, 1'b0);
        tick(); clr_inputs();
        tick(); flush = 1; #1;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b1 || unit_kill !== 1'b0)
            $display("FAIL flush_wb: got vld=%b busy=%b kill=%b required 0/1/0", wb_valid, busy, unit_kill);
        else passed++;
        tick(); flush = 0; #1;
        checks++; if (busy !== 1'b0) $display("FAIL flush_wb_idle: got busy=%b required 0", busy); else passed++;
        // Done and flush in the same cycle: flush wins.
        issue(2'd1, 5'd2, 1'b1);
        tick(); clr_inputs();
        tick(); fpu_done = 1; flush = 1; #1;
        checks++; if (unit_kill !== 1'b1 || wb_valid !== 1'b0)
            $display("FAIL flush_vs_done: got kill=%b vld=%b required 1/0", unit_kill, wb_valid);
        else passed++;
        tick(); clr_inputs(); #1;
        checks++; if (busy !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL flush_vs_done_next: got busy=%b vld=%b required 0/0", busy, wb_valid);
        else passed++;
        // Flush while idle blocks the issue.
        issue(2'd2, 5'd11, 1'b0); flush = 1; #1;
        checks++; if (mul_start !== 1'b0 || stall !== 1'b0)
            $display("FAIL flush_idle_issue: got start=%b stall=%b required 0/0", mul_start, stall);
        else passed++;
        tick(); clr_inputs(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL flush_idle_busy: got %b required 0", busy); else passed++;
    endtask

    task automatic test_basic_ignored();
        issue(2'd0, 5'd12, 1'b0); #1;
        checks++; if ({mul_start, div_start, fpu_start, stall} !== 4'd0)
            $display("FAIL basic_issue: got starts/stall=%b required 0000", {mul_start, div_start, fpu_start, stall});
        else passed++;
        tick(); clr_inputs(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b required 0", busy); else passed++;
    endtask

    task automatic test_x0_and_reset();
        issue(2'd2, 5'd0, 1'b0);
        tick(); clr_inputs();
        id_rs1 = 5'd0; id_rs_bank = 1'b0; #1;
        checks++; if (busy !== 1'b1 || raw_hazard !== 1'b0)
            $display("FAIL x0_hazard: got busy=%b hazard=%b required 1/0", busy, raw_hazard);
        else passed++;
        issue(2'd2, 5'd13, 1'b0);
        rst_n = 0; #1;
        checks++; if ({mul_start, stall, busy, wb_valid, result_sel, wb_rd, wb_rd_bank, raw_hazard, unit_kill} !== 14'd0)
            $display("FAIL async_reset: got %b required 0",
                     {mul_start, stall, busy, wb_valid, result_sel, wb_rd, wb_rd_bank, raw_hazard, unit_kill});
        else passed++;
        clr_inputs();
        tick(); tick();
        rst_n = 1;
        tick(); #1;
        checks++; if (busy !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL post_reset_idle: got busy=%b vld=%b required 0/0", busy, wb_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fpu_bank();
        test_back_to_back();
        test_flush();
        test_basic_ignored();
        test_x0_and_reset();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending writebacks, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
